// File: rtl/parking_gate_fsm.sv
// Vehicle entry/exit detector for a two-beam parking gate: synchronizes and
// debounces both photo-beams, then tracks the beam-crossing order to pulse inc/dec/err.
module parking_gate_fsm #(
    parameter int unsigned DEBOUNCE_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sens_a,
    input  logic sens_b,
    output logic inc,
    output logic dec,
    output logic err,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        EN1,
        EN2,
        EN3,
        EX1,
        EX2,
        EX3,
        ERR
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_LEN - 1);

    logic [1:0] sync_a_q, sync_a_d;
    logic [1:0] sync_b_q, sync_b_d;
    logic       filt_a_q, filt_a_d;
    logic       filt_b_q, filt_b_d;
    logic [7:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;
    state_t     state_q, state_d;
    logic       inc_q, inc_d;
    logic       dec_q, dec_d;
    logic       err_q, err_d;
    logic [1:0] ab;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            filt_a_q <= 1'b0;
            filt_b_q <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            state_q  <= IDLE;
            inc_q    <= 1'b0;
            dec_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            filt_a_q <= filt_a_d;
            filt_b_q <= filt_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            state_q  <= state_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
        end
    end

    // Bit [1] of each synchronizer is the settled level fed to the debouncer.
    always_comb begin
        sync_a_d = {sync_a_q[0], sens_a};
        sync_b_d = {sync_b_q[0], sens_b};
        filt_a_d = filt_a_q;
        filt_b_d = filt_b_q;
        cnt_a_d  = '0;
        cnt_b_d  = '0;

        if (sync_a_q[1] != filt_a_q) begin
            if (cnt_a_q == CNT_LAST) begin
                filt_a_d = sync_a_q[1];
            end else begin
                cnt_a_d = cnt_a_q + 8'd1;
            end
        end

        if (sync_b_q[1] != filt_b_q) begin
            if (cnt_b_q == CNT_LAST) begin
                filt_b_d = sync_b_q[1];
            end else begin
                cnt_b_d = cnt_b_q + 8'd1;
            end
        end
    end

    assign ab = {filt_a_q, filt_b_q};

    always_comb begin
        state_d = state_q;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                unique case (ab)
                    2'b00: state_d = IDLE;
                    2'b10: state_d = EN1;
                    2'b01: state_d = EX1;
                    2'b11: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EN1: begin
                unique case (ab)
                    2'b10: state_d = EN1;
                    2'b11: state_d = EN2;
                    2'b00: state_d = IDLE;
                    2'b01: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EN2: begin
                unique case (ab)
                    2'b11: state_d = EN2;
                    2'b01: state_d = EN3;
                    2'b10: state_d = EN1;
                    2'b00: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EN3: begin
                unique case (ab)
                    2'b01: state_d = EN3;
                    2'b00: begin state_d = IDLE; inc_d = 1'b1; end
                    2'b11: state_d = EN2;
                    2'b10: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EX1: begin
                unique case (ab)
                    2'b01: state_d = EX1;
                    2'b11: state_d = EX2;
                    2'b00: state_d = IDLE;
                    2'b10: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EX2: begin
                unique case (ab)
                    2'b11: state_d = EX2;
                    2'b10: state_d = EX3;
                    2'b01: state_d = EX1;
                    2'b00: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            EX3: begin
                unique case (ab)
                    2'b10: state_d = EX3;
                    2'b00: begin state_d = IDLE; dec_d = 1'b1; end
                    2'b11: state_d = EX2;
                    2'b01: begin state_d = ERR; err_d = 1'b1; end
                endcase
            end
            ERR: begin
                if (ab == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inc  = inc_q;
    assign dec  = dec_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_parking_gate_fsm.sv
// Self-checking bench for parking_gate_fsm: directed scenarios plus a random
// beam walk, compared every clock against a path-position reference model.
module tb_parking_gate_fsm;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sens_a = 1'b0;
    logic sens_b = 1'b0;
    logic inc, dec, err, busy;

    parking_gate_fsm #(.DEBOUNCE_LEN(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .sens_a (sens_a),
        .sens_b (sens_b),
        .inc    (inc),
        .dec    (dec),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_inc = 0, n_dec = 0, n_err = 0;
    int inc_cyc = -1;

    // Model: mode 0 idle, 1 entering, 2 exiting, 3 error; pos = index along the path.
    int m_mode, m_pos;
    bit m_fa, m_fb;
    bit m_inc, m_dec, m_err;
    bit qa[$];
    bit qb[$];
    int path [2][4] = '{'{0, 2, 3, 1}, '{0, 1, 3, 2}};

    task automatic model_reset();
        m_mode = 0; m_pos = 0;
        m_fa = 0; m_fb = 0;
        m_inc = 0; m_dec = 0; m_err = 0;
        qa.delete(); qb.delete();
        for (int i = 0; i < DEB + 2; i++) begin
            qa.push_back(1'b0);
            qb.push_back(1'b0);
        end
    endtask

    // A filtered level flips once the last DEB synchronized samples all disagree with it.
    function automatic bit window_flips(bit q[$], bit f);
        for (int i = 2; i < DEB + 2; i++)
            if (q[i] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(bit a, bit b);
        int ab, p;
        ab = (m_fa ? 2 : 0) + (m_fb ? 1 : 0);
        m_inc = 0; m_dec = 0; m_err = 0;
        case (m_mode)
            0: begin
                if (ab == 2) begin m_mode = 1; m_pos = 1; end
                else if (ab == 1) begin m_mode = 2; m_pos = 1; end
                else if (ab == 3) begin m_mode = 3; m_err = 1; end
            end
            1, 2: begin
                p = m_mode - 1;
                if (ab == path[p][m_pos]) begin
                end else if (m_pos < 3 && ab == path[p][m_pos + 1]) begin
                    m_pos++;
                end else if (m_pos == 3 && ab == 0) begin
                    if (m_mode == 1) m_inc = 1; else m_dec = 1;
                    m_mode = 0; m_pos = 0;
                end else if (ab == path[p][m_pos - 1]) begin
                    m_pos--;
                    if (m_pos == 0) m_mode = 0;
                end else begin
                    m_mode = 3; m_err = 1;
                end
            end
            default: if (ab == 0) m_mode = 0;
        endcase
        qa.push_front(a); void'(qa.pop_back());
        qb.push_front(b); void'(qb.pop_back());
        if (window_flips(qa, m_fa)) m_fa = !m_fa;
        if (window_flips(qb, m_fb)) m_fb = !m_fb;
    endtask

    task automatic check_outputs();
        checks++;
        assert (inc === m_inc) else begin errors++; $error("FAIL inc @cyc %0d: got %b expected %b", cyc, inc, m_inc); end
        checks++;
        assert (dec === m_dec) else begin errors++; $error("FAIL dec @cyc %0d: got %b expected %b", cyc, dec, m_dec); end
        checks++;
        assert (err === m_err) else begin errors++; $error("FAIL err @cyc %0d: got %b expected %b", cyc, err, m_err); end
        checks++;
        assert (busy === (m_mode != 0)) else begin errors++; $error("FAIL busy @cyc %0d: got %b expected %b", cyc, busy, m_mode != 0); end
    endtask

    task automatic check_int(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin errors++; $error("FAIL %s: got %0d expected %0d", tag, got, exp); end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_edge(sens_a, sens_b);
        #1;
        check_outputs();
        if (inc === 1'b1) begin n_inc++; inc_cyc = cyc; end
        if (dec === 1'b1) n_dec++;
        if (err === 1'b1) n_err++;
    endtask

    task automatic hold(bit a, bit b, int n);
        sens_a = a;
        sens_b = b;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        int i0, d0, e0, t0, cur;
        model_reset();
        #2;
        check_outputs();
        repeat (2) tick();
        reset = 1'b0;
        hold(0, 0, 3);

        // Full entry with end-to-end latency measurement
        i0 = n_inc; d0 = n_dec; e0 = n_err;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        sens_a = 0; sens_b = 0;
        t0 = cyc; inc_cyc = -1;
        for (int i = 0; i < 20 && inc_cyc < 0; i++) tick();
        check_int("entry_latency", inc_cyc - t0, 2 + DEB + 1);
        hold(0, 0, 5);
        check_int("entry_inc", n_inc - i0, 1);
        check_int("entry_dec", n_dec - d0, 0);
        check_int("entry_err", n_err - e0, 0);

        // Full exit
        i0 = n_inc; d0 = n_dec; e0 = n_err;
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 15);
        check_int("exit_dec", n_dec - d0, 1);
        check_int("exit_inc", n_inc - i0, 0);
        check_int("exit_err", n_err - e0, 0);

        // Back-out
        i0 = n_inc; d0 = n_dec; e0 = n_err;
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 15);
        check_int("backout_pulses", (n_inc - i0) + (n_dec - d0) + (n_err - e0), 0);
        check_int("backout_busy", int'(busy), 0);

        // Glitch shorter than the debounce window
        i0 = n_inc; d0 = n_dec; e0 = n_err;
        hold(1, 0, DEB - 1); hold(0, 0, 12);
        check_int("glitch_pulses", (n_inc - i0) + (n_dec - d0) + (n_err - e0), 0);

        // Both beams at once
        i0 = n_inc; d0 = n_dec; e0 = n_err;
        hold(1, 1, 12);
        check_int("illegal_busy_held", int'(busy), 1);
        hold(0, 0, 12);
        check_int("illegal_err", n_err - e0, 1);
        check_int("illegal_incdec", (n_inc - i0) + (n_dec - d0), 0);
        check_int("illegal_busy_after", int'(busy), 0);

        // Reset while in EN3
        i0 = n_inc;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        check_int("en3_busy", int'(busy), 1);
        sens_a = 0; sens_b = 0;
        do_reset();
        hold(0, 0, 15);
        check_int("midreset_no_inc", n_inc - i0, 0);

        // Beams blocked across reset are seen afresh from 00
        e0 = n_err;
        hold(1, 1, 12);
        do_reset();
        hold(1, 1, 12);
        hold(0, 0, 12);
        check_int("held11_err", n_err - e0, 2);

        // Random beam walk, mostly single-bit steps so full passages occur
        cur = 0;
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 3) < 3) cur = cur ^ (1 << $urandom_range(0, 1));
            else cur = int'($urandom_range(0, 3));
            hold(cur[1], cur[0], int'($urandom_range(1, 10)));
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        hold(0, 0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
